// File: rtl/pcie_cfg_mgmt_responder_pkg.sv
// pcie_cfg_mgmt_responder_pkg: shared widths, register offsets, DEVCTL layout and FSM states
package pcie_cfg_mgmt_responder_pkg;
    localparam int ADDR_W = 10;
    localparam int FUNC_W = 8;
    localparam int DATA_W = 32;
    localparam int BE_W = 4;
    localparam int FIELD_W = 3;
    localparam logic [ADDR_W-1:0] ID_ADDR = 10'h000;
    localparam logic [ADDR_W-1:0] DEVCTL_ADDR_DEF = 10'h01E;
    localparam logic [DATA_W-1:0] DEVCTL_RST = 32'h0000_2000;
    localparam int MPS_LSB = 5;
    localparam int MRRS_LSB = 12;
    typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_DONE} state_e;
endpackage

// File: rtl/pcie_cfg_mgmt_responder_regfile.sv
// pcie_cfg_mgmt_responder_regfile: per-function config dwords with registered read and byte-enabled write
module pcie_cfg_mgmt_responder_regfile
    import pcie_cfg_mgmt_responder_pkg::*;
#(
    parameter int NUM_FUNC = 4,
    parameter int REG_COUNT = 64,
    parameter int FW = 2,
    parameter int AW = 6,
    parameter logic [15:0] VENDOR_ID = 16'h1234,
    parameter logic [15:0] DEVICE_ID = 16'h0001,
    parameter logic [ADDR_W-1:0] DEVCTL_ADDR = DEVCTL_ADDR_DEF
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              rd_en_i,
    input  logic              hit_i,
    input  logic              wr_en_i,
    input  logic [FW-1:0]     func_i,
    input  logic [AW-1:0]     addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [BE_W-1:0]   be_i,
    output logic [DATA_W-1:0] rdata_o,
    output logic [FIELD_W-1:0] mps_o,
    output logic [FIELD_W-1:0] mrrs_o
);
    logic [DATA_W-1:0] mem_q [NUM_FUNC][REG_COUNT];
    logic [DATA_W-1:0] rdata_q;
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            for (int f = 0; f < NUM_FUNC; f++)
                for (int a = 0; a < REG_COUNT; a++)
                    mem_q[f][a] <= (a == 0) ? {DEVICE_ID, VENDOR_ID} :
                                   (ADDR_W'(a) == DEVCTL_ADDR) ? DEVCTL_RST : '0;
            rdata_q <= '0;
        end else begin
            if (wr_en_i && addr_i != ID_ADDR[AW-1:0])
                for (int b = 0; b < BE_W; b++)
                    if (be_i[b]) mem_q[func_i][addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
            if (rd_en_i) rdata_q <= hit_i ? mem_q[func_i][addr_i] : '0;
        end
    end
    assign rdata_o = rdata_q;
    assign mps_o = mem_q[0][DEVCTL_ADDR[AW-1:0]][MPS_LSB +: FIELD_W];
    assign mrrs_o = mem_q[0][DEVCTL_ADDR[AW-1:0]][MRRS_LSB +: FIELD_W];
endmodule

// File: rtl/pcie_cfg_mgmt_responder.sv
// pcie_cfg_mgmt_responder: cfg_mgmt completer with latency FSM, range check and DEVCTL-derived limits
module pcie_cfg_mgmt_responder
    import pcie_cfg_mgmt_responder_pkg::*;
#(
    parameter int NUM_FUNC = 4,
    parameter int REG_COUNT = 64,
    parameter int RESP_LATENCY = 2,
    parameter logic [15:0] VENDOR_ID = 16'h1234,
    parameter logic [15:0] DEVICE_ID = 16'h0001,
    parameter logic [ADDR_W-1:0] DEVCTL_ADDR = DEVCTL_ADDR_DEF
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic [ADDR_W-1:0]  cfg_mgmt_addr_i,
    input  logic [FUNC_W-1:0]  cfg_mgmt_function_number_i,
    input  logic               cfg_mgmt_write_i,
    input  logic [DATA_W-1:0]  cfg_mgmt_write_data_i,
    input  logic [BE_W-1:0]    cfg_mgmt_byte_enable_i,
    input  logic               cfg_mgmt_read_i,
    output logic [DATA_W-1:0]  cfg_mgmt_read_data_o,
    output logic               cfg_mgmt_read_write_done_o,
    output logic [FIELD_W-1:0] cfg_max_payload_o,
    output logic [FIELD_W-1:0] cfg_max_read_req_o,
    output logic               protocol_error_o
);
    localparam int AW = $clog2(REG_COUNT);
    localparam int FW = NUM_FUNC > 1 ? $clog2(NUM_FUNC) : 1;
    localparam int CW = RESP_LATENCY > 1 ? $clog2(RESP_LATENCY) : 1;
    localparam logic [FUNC_W-1:0] NF = FUNC_W'(NUM_FUNC);
    localparam logic [ADDR_W:0] RC = (ADDR_W+1)'(REG_COUNT);
    state_e state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q;
    logic [FUNC_W-1:0] func_q;
    logic [DATA_W-1:0] wdata_q;
    logic [BE_W-1:0] be_q;
    logic wr_q, err_q;
    logic [FIELD_W-1:0] mps_q, mrrs_q, mps_w, mrrs_w;
    logic req, hit, fire;
    assign req = cfg_mgmt_read_i | cfg_mgmt_write_i;
    assign hit = (func_q < NF) && ({1'b0, addr_q} < RC);
    // Completion edge: last BUSY cycle with the request still held
    assign fire = state_q == ST_BUSY && req && cnt_q == '0;
    always_comb begin
        state_d = state_q;
        cnt_d = cnt_q;
        case (state_q)
            ST_IDLE: if (req) begin
                state_d = ST_BUSY;
                cnt_d = CW'(RESP_LATENCY - 1);
            end
            ST_BUSY: begin
                state_d = !req ? ST_IDLE : (cnt_q == '0) ? ST_DONE : ST_BUSY;
                cnt_d = (cnt_q == '0) ? cnt_q : cnt_q - 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
    end
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q <= ST_IDLE;
            cnt_q <= '0;
            addr_q <= '0;
            func_q <= '0;
            wdata_q <= '0;
            be_q <= '0;
            wr_q <= 1'b0;
            err_q <= 1'b0;
            mps_q <= DEVCTL_RST[MPS_LSB +: FIELD_W];
            mrrs_q <= DEVCTL_RST[MRRS_LSB +: FIELD_W];
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            if (state_q == ST_IDLE && req) begin
                addr_q <= cfg_mgmt_addr_i;
                func_q <= cfg_mgmt_function_number_i;
                wdata_q <= cfg_mgmt_write_data_i;
                be_q <= cfg_mgmt_byte_enable_i;
                wr_q <= cfg_mgmt_write_i;
                err_q <= cfg_mgmt_read_i & cfg_mgmt_write_i;
            end
            mps_q <= mps_w;
            mrrs_q <= mrrs_w;
        end
    end
    pcie_cfg_mgmt_responder_regfile #(
        .NUM_FUNC(NUM_FUNC), .REG_COUNT(REG_COUNT), .FW(FW), .AW(AW),
        .VENDOR_ID(VENDOR_ID), .DEVICE_ID(DEVICE_ID), .DEVCTL_ADDR(DEVCTL_ADDR)
    ) u_regfile (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .rd_en_i (fire & ~wr_q),
        .hit_i   (hit),
        .wr_en_i (fire & wr_q & hit),
        .func_i  (func_q[FW-1:0]),
        .addr_i  (addr_q[AW-1:0]),
        .wdata_i (wdata_q),
        .be_i    (be_q),
        .rdata_o (cfg_mgmt_read_data_o),
        .mps_o   (mps_w),
        .mrrs_o  (mrrs_w)
    );
    assign cfg_mgmt_read_write_done_o = state_q == ST_DONE;
    assign protocol_error_o = state_q == ST_DONE && err_q;
    assign cfg_max_payload_o = mps_q;
    assign cfg_max_read_req_o = mrrs_q;
endmodule

// File: tb/tb_pcie_cfg_mgmt_responder.sv
// tb_pcie_cfg_mgmt_responder: directed checks of the cfg_mgmt completer
module tb_pcie_cfg_mgmt_responder;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [9:0] addr = '0;
    logic [7:0] func = '0;
    logic wr = 1'b0;
    logic [31:0] wdata = '0;
    logic [3:0] be = '0;
    logic rd = 1'b0;
    logic [31:0] rdata;
    logic done, perr;
    logic [2:0] mps, mrrs;
    int n_pass = 0;
    int n_chk = 0;
    logic [31:0] r;
    logic e;
    logic [2:0] m;
    int lat;
    logic seen;

    always #5 clk = ~clk;

    pcie_cfg_mgmt_responder dut (
        .clk_i                      (clk),
        .rst_n_i                    (rst_n),
        .cfg_mgmt_addr_i            (addr),
        .cfg_mgmt_function_number_i (func),
        .cfg_mgmt_write_i           (wr),
        .cfg_mgmt_write_data_i      (wdata),
        .cfg_mgmt_byte_enable_i     (be),
        .cfg_mgmt_read_i            (rd),
        .cfg_mgmt_read_data_o       (rdata),
        .cfg_mgmt_read_write_done_o (done),
        .cfg_max_payload_o          (mps),
        .cfg_max_read_req_o         (mrrs),
        .protocol_error_o           (perr)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic access(input logic r_i, input logic w_i, input logic [7:0] f_i,
                          input logic [9:0] a_i, input logic [31:0] d_i, input logic [3:0] be_i,
                          output logic [31:0] rd_o, output logic err_o, output logic [2:0] mps_o,
                          output int lat_o);
        rd = r_i;
        wr = w_i;
        func = f_i;
        addr = a_i;
        wdata = d_i;
        be = be_i;
        lat_o = -1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (done) begin
                lat_o = k;
                break;
            end
        end
        rd_o = rdata;
        err_o = perr;
        mps_o = mps;
        rd = 1'b0;
        wr = 1'b0;
        @(negedge clk);
        chk("done_one_cycle", {31'b0, done}, 32'd0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_perr", {31'b0, perr}, 32'd0);
        chk("rst_mps", {29'b0, mps}, 32'd0);
        chk("rst_mrrs", {29'b0, mrrs}, 32'd2);
        rst_n = 1'b1;
        access(1, 0, 8'd0, 10'h000, 32'h0, 4'h0, r, e, m, lat);
        chk("t1_lat", 32'(lat), 32'd2);
        chk("t1_id", r, 32'h0001_1234);
        chk("t1_perr", {31'b0, e}, 32'd0);
        access(0, 1, 8'd1, 10'h005, 32'hDEAD_BEEF, 4'b0101, r, e, m, lat);
        chk("t2_wr_lat", 32'(lat), 32'd2);
        access(1, 0, 8'd1, 10'h005, 32'h0, 4'h0, r, e, m, lat);
        chk("t2_rd", r, 32'h00AD_00EF);
        access(0, 1, 8'd0, 10'h01E, 32'h0000_50A0, 4'hF, r, e, m, lat);
        chk("t3_mps_in_done", {29'b0, m}, 32'd0);
        chk("t3_mps", {29'b0, mps}, 32'd5);
        chk("t3_mrrs", {29'b0, mrrs}, 32'd5);
        access(1, 0, 8'd0, 10'h01E, 32'h0, 4'h0, r, e, m, lat);
        chk("t3_devctl_rd", r, 32'h0000_50A0);
        access(0, 1, 8'd0, 10'h000, 32'hFFFF_FFFF, 4'hF, r, e, m, lat);
        chk("t4_wr_lat", 32'(lat), 32'd2);
        access(1, 0, 8'd0, 10'h000, 32'h0, 4'h0, r, e, m, lat);
        chk("t4_id_ro", r, 32'h0001_1234);
        access(1, 0, 8'd7, 10'h003, 32'h0, 4'h0, r, e, m, lat);
        chk("t5_f7_lat", 32'(lat), 32'd2);
        chk("t5_f7_rd", r, 32'd0);
        access(1, 0, 8'd1, 10'h005, 32'h0, 4'h0, r, e, m, lat);
        chk("t5_prev_rd", r, 32'h00AD_00EF);
        access(1, 0, 8'd0, 10'h3FF, 32'h0, 4'h0, r, e, m, lat);
        chk("t5_addr_lat", 32'(lat), 32'd2);
        chk("t5_addr_rd", r, 32'd0);
        access(0, 1, 8'd7, 10'h003, 32'hAAAA_AAAA, 4'hF, r, e, m, lat);
        chk("t5_f7_wr_lat", 32'(lat), 32'd2);
        access(1, 0, 8'd3, 10'h003, 32'h0, 4'h0, r, e, m, lat);
        chk("t5_f3_untouched", r, 32'd0);
        access(0, 1, 8'd0, 10'h045, 32'h5555_5555, 4'hF, r, e, m, lat);
        access(1, 0, 8'd0, 10'h005, 32'h0, 4'h0, r, e, m, lat);
        chk("t5_f0a5_untouched", r, 32'd0);
        access(1, 1, 8'd2, 10'h004, 32'h1, 4'hF, r, e, m, lat);
        chk("t6_both_lat", 32'(lat), 32'd2);
        chk("t6_perr", {31'b0, e}, 32'd1);
        access(1, 0, 8'd2, 10'h004, 32'h0, 4'h0, r, e, m, lat);
        chk("t6_readback", r, 32'h1);
        chk("t6_perr_read", {31'b0, e}, 32'd0);
        wr = 1'b1;
        func = 8'd2;
        addr = 10'h004;
        wdata = 32'h55;
        be = 4'hF;
        @(negedge clk);
        wr = 1'b0;
        seen = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        chk("abort_no_done", {31'b0, seen}, 32'd0);
        access(1, 0, 8'd2, 10'h004, 32'h0, 4'h0, r, e, m, lat);
        chk("abort_no_commit", r, 32'h1);
        wr = 1'b1;
        func = 8'd0;
        addr = 10'h01E;
        wdata = 32'h0;
        @(negedge clk);
        rst_n = 1'b0;
        wr = 1'b0;
        seen = 1'b0;
        repeat (2) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        chk("rstmid_no_done", {31'b0, seen}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rstmid_mrrs", {29'b0, mrrs}, 32'd2);
        chk("rstmid_mps", {29'b0, mps}, 32'd0);
        access(1, 0, 8'd2, 10'h004, 32'h0, 4'h0, r, e, m, lat);
        chk("rstmid_cleared", r, 32'd0);
        access(1, 0, 8'd0, 10'h01E, 32'h0, 4'h0, r, e, m, lat);
        chk("rstmid_devctl", r, 32'h0000_2000);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
